// File: rtl/user_project_la_loopback_if.sv
// Logic-analyser loopback bus: LA data/mask from the management core,
// looped-back data, mode select, change-flag clear and interrupt.
interface user_project_la_loopback_if #(
    parameter int NBANKS = 4,
    parameter int BANK_W = 32
);
    logic [NBANKS*BANK_W-1:0] la_data_in;
    logic [NBANKS*BANK_W-1:0] la_oenb;
    logic [NBANKS*BANK_W-1:0] la_data_out;
    logic [1:0]               mode_i;
    logic                     chg_clr_i;
    logic                     irq;

    modport slave (
        input  la_data_in, la_oenb, mode_i, chg_clr_i,
        output la_data_out, irq
    );

    modport master (
        output la_data_in, la_oenb, mode_i, chg_clr_i,
        input  la_data_out, irq
    );
endinterface

// File: rtl/user_project_la_loopback.sv
// LA loopback: each destination bank d is fed from its pair bank d^1 through
// a LAT-deep register pipeline. Modes: 00 SWAP, 01 HOLD, 10 INVERT, 11 COUNT.
// Output bits are masked by the source bank's la_oenb (combinational).
// Optional change detector compiled in with LA_LOOPBACK_CHANGE_DETECT_EN;
// without it irq is tied low and chg_clr_i is ignored.

// One destination bank: stage-0 source select, delay pipeline, counter, chg flag.
module user_project_la_loopback_bank #(
    parameter int BANK_W = 32,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic [BANK_W-1:0] src_data,
    input  logic [BANK_W-1:0] src_oenb,
    input  logic              chg_clr,
    output logic [BANK_W-1:0] data_out,
    output logic              chg
);
    typedef enum logic [1:0] {
        MODE_SWAP   = 2'b00,
        MODE_HOLD   = 2'b01,
        MODE_INVERT = 2'b10,
        MODE_COUNT  = 2'b11
    } mode_e;

    logic [LAT-1:0][BANK_W-1:0] stage;
    logic [BANK_W-1:0]          s0_nxt;
    logic [BANK_W-1:0]          cnt;

    // Stage-0 next value; only the mode sampled at this edge picks the source
    always_comb begin
        s0_nxt = stage[0];
        case (mode)
            MODE_SWAP:   s0_nxt = src_data;
            MODE_INVERT: s0_nxt = ~src_data;
            MODE_COUNT:  s0_nxt = cnt;
            default:     s0_nxt = stage[0];
        endcase
    end

    // Pipeline: HOLD freezes every stage, otherwise shift one stage per edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
        end else if (mode != MODE_HOLD) begin
            stage[0] <= s0_nxt;
            for (int k = 1; k < LAT; k++) stage[k] <= stage[k-1];
        end
    end

    // Free-running counter, advances only in COUNT, wraps silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   cnt <= '0;
        else if (mode == MODE_COUNT)  cnt <= cnt + 1'b1;
    end

    assign data_out = stage[LAT-1] & ~src_oenb;

`ifdef LA_LOOPBACK_CHANGE_DETECT_EN
    logic chg_set;
    assign chg_set = ((mode == MODE_SWAP) || (mode == MODE_INVERT)) && (s0_nxt != stage[0]);

    // Sticky change flag; a set on the same edge as a clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       chg <= 1'b0;
        else if (chg_set) chg <= 1'b1;
        else if (chg_clr) chg <= 1'b0;
    end
`else
    logic unused_chg_clr;
    assign unused_chg_clr = chg_clr;
    assign chg            = 1'b0;
`endif
endmodule

// Top: pairs banks (0<->1, 2<->3, ...) and ORs the change flags into irq.
module user_project_la_loopback #(
    parameter int NBANKS = 4,
    parameter int BANK_W = 32,
    parameter int LAT    = 2
) (
    input  logic                  wb_clk_i,
    input  logic                  resetb,
    user_project_la_loopback_if.slave bus
);
    logic [NBANKS-1:0][BANK_W-1:0] data_in;
    logic [NBANKS-1:0][BANK_W-1:0] oenb;
    logic [NBANKS-1:0][BANK_W-1:0] data_out;
    logic [NBANKS-1:0]             chg;

    assign data_in = bus.la_data_in;
    assign oenb    = bus.la_oenb;

    for (genvar d = 0; d < NBANKS; d++) begin : g_bank
        localparam int S = d ^ 1;
        user_project_la_loopback_bank #(
            .BANK_W (BANK_W),
            .LAT    (LAT)
        ) u_bank (
            .clk      (wb_clk_i),
            .rst_n    (resetb),
            .mode     (bus.mode_i),
            .src_data (data_in[S]),
            .src_oenb (oenb[S]),
            .chg_clr  (bus.chg_clr_i),
            .data_out (data_out[d]),
            .chg      (chg[d])
        );
    end

    assign bus.la_data_out = data_out;
    assign bus.irq         = |chg;
endmodule

// File: tb/tb_user_project_la_loopback.sv
// Bench for user_project_la_loopback: directed scenarios plus a randomized run,
// checked against a load-history model (output = value loaded LAT loads ago).
module tb_user_project_la_loopback;
    localparam int NB    = 4;
    localparam int BW    = 32;
    localparam int LT    = 2;
    localparam int MAXLD = 4096;
    localparam logic [1:0] M_SWAP = 2'b00, M_HOLD = 2'b01, M_INV = 2'b10, M_CNT = 2'b11;

    logic wb_clk_i = 1'b0;
    logic resetb   = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    user_project_la_loopback_if #(.NBANKS(NB), .BANK_W(BW)) bus ();
    user_project_la_loopback_if #(.NBANKS(2),  .BANK_W(4))  bus_w ();

    user_project_la_loopback #(.NBANKS(NB), .BANK_W(BW), .LAT(LT)) u_dut (
        .wb_clk_i (wb_clk_i),
        .resetb   (resetb),
        .bus      (bus)
    );

    // Narrow, single-stage instance so the counter wrap is reachable quickly
    user_project_la_loopback #(.NBANKS(2), .BANK_W(4), .LAT(1)) u_dut_w (
        .wb_clk_i (wb_clk_i),
        .resetb   (resetb),
        .bus      (bus_w)
    );

    int checks = 0;
    int errors = 0;

    // Model: per-bank history of every value loaded into stage 0 since reset
    logic [BW-1:0] ent [NB][MAXLD];
    int            n_ld  [NB];
    logic [BW-1:0] cnt_m [NB];
    logic          chg_m [NB];

    function automatic logic [BW-1:0] bank_of(input logic [NB*BW-1:0] v, input int b);
        return v[b*BW +: BW];
    endfunction

    task automatic set_bank(input int b, input logic [BW-1:0] v);
        bus.la_data_in[b*BW +: BW] = v;
    endtask

    task automatic set_oenb(input int b, input logic [BW-1:0] v);
        bus.la_oenb[b*BW +: BW] = v;
    endtask

    function automatic logic [BW-1:0] exp_out(input int d);
        logic [BW-1:0] v;
        v = (n_ld[d] >= LT) ? ent[d][n_ld[d]-LT] : '0;
        return v & ~bank_of(bus.la_oenb, d ^ 1);
    endfunction

    function automatic logic [NB*BW-1:0] exp_vec();
        logic [NB*BW-1:0] e;
        for (int d = 0; d < NB; d++) e[d*BW +: BW] = exp_out(d);
        return e;
    endfunction

    function automatic logic exp_irq();
        logic r;
        r = 1'b0;
        for (int d = 0; d < NB; d++) r = r | chg_m[d];
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < NB; d++) begin
            n_ld[d]  = 0;
            cnt_m[d] = '0;
            chg_m[d] = 1'b0;
        end
    endtask

    // Apply the rules for one rising edge using the inputs currently driven
    task automatic model_step();
        logic [BW-1:0] src, cur, nv;
        for (int d = 0; d < NB; d++) begin
            src = bank_of(bus.la_data_in, d ^ 1);
            cur = (n_ld[d] > 0) ? ent[d][n_ld[d]-1] : '0;
            nv  = cur;
            case (bus.mode_i)
                M_SWAP:  nv = src;
                M_INV:   nv = ~src;
                M_CNT:   nv = cnt_m[d];
                default: nv = cur;
            endcase
`ifdef LA_LOOPBACK_CHANGE_DETECT_EN
            if ((bus.mode_i == M_SWAP || bus.mode_i == M_INV) && nv != cur) chg_m[d] = 1'b1;
            else if (bus.chg_clr_i) chg_m[d] = 1'b0;
`endif
            if (bus.mode_i != M_HOLD && n_ld[d] < MAXLD) begin
                ent[d][n_ld[d]] = nv;
                n_ld[d]++;
            end
            if (bus.mode_i == M_CNT) cnt_m[d] = cnt_m[d] + 1'b1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        @(posedge wb_clk_i);
        #1;
        resetb = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        bus.la_data_in = {$urandom, $urandom, $urandom, $urandom};
        bus.la_oenb    = '0;
        bus.mode_i     = M_SWAP;
        bus.chg_clr_i  = 1'b0;
        resetb = 1'b0;
        repeat (2) @(posedge wb_clk_i);
        #1;
        checks++;
        if (bus.la_data_out !== '0) begin
            errors++; $display("FAIL reset_out got %h exp 0", bus.la_data_out);
        end
        checks++;
        if (bus.irq !== 1'b0) begin
            errors++; $display("FAIL reset_irq got %b exp 0", bus.irq);
        end
        resetb = 1'b1;
        model_reset();
    endtask

    task automatic test_swap_latency();
        do_reset();
        bus.mode_i  = M_SWAP;
        bus.la_oenb = '0;
        bus.la_data_in = {$urandom, $urandom, $urandom, $urandom};
        set_bank(0, 32'hDEADBEEF);
        tick();
        checks++;
        if (bank_of(bus.la_data_out, 1) !== 32'h0) begin
            errors++; $display("FAIL swap_early got %h exp 0", bank_of(bus.la_data_out, 1));
        end
        tick();
        checks++;
        if (bank_of(bus.la_data_out, 1) !== 32'hDEADBEEF) begin
            errors++; $display("FAIL swap_lat got %h exp deadbeef", bank_of(bus.la_data_out, 1));
        end
        checks++;
        if (bus.la_data_out !== exp_vec()) begin
            errors++; $display("FAIL swap_vec got %h exp %h", bus.la_data_out, exp_vec());
        end
    endtask

    task automatic test_invert_mask();
        bus.mode_i  = M_INV;
        bus.la_oenb = '0;
        set_bank(3, 32'h0000FFFF);
        tick();
        tick();
        checks++;
        if (bank_of(bus.la_data_out, 2) !== 32'hFFFF0000) begin
            errors++; $display("FAIL inv_out got %h exp ffff0000", bank_of(bus.la_data_out, 2));
        end
        set_oenb(3, 32'h000000FF);
        #1;
        checks++;
        if (bank_of(bus.la_data_out, 2) !== 32'hFFFF0000) begin
            errors++; $display("FAIL mask_low got %h exp ffff0000", bank_of(bus.la_data_out, 2));
        end
        set_oenb(3, 32'hFF000000);
        #1;
        checks++;
        if (bank_of(bus.la_data_out, 2) !== 32'h00FF0000) begin
            errors++; $display("FAIL mask_high got %h exp 00ff0000", bank_of(bus.la_data_out, 2));
        end
        checks++;
        if (bus.la_data_out !== exp_vec()) begin
            errors++; $display("FAIL mask_vec got %h exp %h", bus.la_data_out, exp_vec());
        end
        bus.la_oenb = '0;
    endtask

    task automatic test_count();
        do_reset();
        bus.mode_i  = M_CNT;
        bus.la_oenb = '0;
        for (int n = 1; n <= 5 + LT; n++) begin
            tick();
            checks++;
            if (bus.la_data_out !== exp_vec()) begin
                errors++; $display("FAIL count_vec n=%0d got %h exp %h", n, bus.la_data_out, exp_vec());
            end
            if (n >= LT) begin
                for (int d = 0; d < NB; d++) begin
                    checks++;
                    if (bank_of(bus.la_data_out, d) !== BW'(n - LT)) begin
                        errors++; $display("FAIL count_seq bank%0d got %h exp %h", d, bank_of(bus.la_data_out, d), n - LT);
                    end
                end
            end
        end
    endtask

    task automatic test_hold();
        bus.mode_i  = M_SWAP;
        bus.la_oenb = '0;
        set_bank(0, 32'h1);
        tick();
        tick();
        bus.mode_i = M_HOLD;
        set_bank(0, 32'h2);
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if (bank_of(bus.la_data_out, 1) !== 32'h1) begin
                errors++; $display("FAIL hold_keep got %h exp 1", bank_of(bus.la_data_out, 1));
            end
        end
        bus.mode_i = M_SWAP;
        tick();
        checks++;
        if (bank_of(bus.la_data_out, 1) !== 32'h1) begin
            errors++; $display("FAIL hold_drain got %h exp 1", bank_of(bus.la_data_out, 1));
        end
        tick();
        checks++;
        if (bank_of(bus.la_data_out, 1) !== 32'h2) begin
            errors++; $display("FAIL hold_resume got %h exp 2", bank_of(bus.la_data_out, 1));
        end
    endtask

    task automatic test_change_irq();
        logic exp_set;
`ifdef LA_LOOPBACK_CHANGE_DETECT_EN
        exp_set = 1'b1;
`else
        exp_set = 1'b0;
`endif
        do_reset();
        bus.mode_i     = M_SWAP;
        bus.la_data_in = '0;
        bus.la_oenb    = '0;
        bus.chg_clr_i  = 1'b0;
        tick();
        checks++;
        if (bus.irq !== 1'b0) begin
            errors++; $display("FAIL irq_idle got %b exp 0", bus.irq);
        end
        set_bank(2, 32'h5);
        tick();
        checks++;
        if (bus.irq !== exp_set) begin
            errors++; $display("FAIL irq_set got %b exp %b", bus.irq, exp_set);
        end
        set_bank(2, 32'h6);
        bus.chg_clr_i = 1'b1;
        tick();
        checks++;
        if (bus.irq !== exp_set) begin
            errors++; $display("FAIL irq_set_wins got %b exp %b", bus.irq, exp_set);
        end
        tick();
        checks++;
        if (bus.irq !== 1'b0) begin
            errors++; $display("FAIL irq_clr got %b exp 0", bus.irq);
        end
        checks++;
        if (bus.irq !== exp_irq()) begin
            errors++; $display("FAIL irq_model got %b exp %b", bus.irq, exp_irq());
        end
        bus.chg_clr_i = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 300; n++) begin
            bus.mode_i     = 2'($urandom_range(0, 3));
            bus.la_data_in = {$urandom, $urandom, $urandom, $urandom};
            bus.la_oenb    = {$urandom & $urandom, $urandom & $urandom,
                              $urandom & $urandom, $urandom & $urandom};
            bus.chg_clr_i  = ($urandom_range(0, 3) == 0);
            tick();
            checks++;
            if (bus.la_data_out !== exp_vec()) begin
                errors++; $display("FAIL rand_out n=%0d got %h exp %h", n, bus.la_data_out, exp_vec());
            end
            checks++;
            if (bus.irq !== exp_irq()) begin
                errors++; $display("FAIL rand_irq n=%0d got %b exp %b", n, bus.irq, exp_irq());
            end
        end
        bus.chg_clr_i = 1'b0;
        bus.la_oenb   = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.mode_i  = M_CNT;
        bus.la_oenb = '0;
        repeat (7) tick();
        checks++;
        if (bank_of(bus.la_data_out, 0) !== BW'(7 - LT)) begin
            errors++; $display("FAIL ar_pre got %h exp %h", bank_of(bus.la_data_out, 0), 7 - LT);
        end
        #2;
        resetb = 1'b0;
        #1;
        checks++;
        if (bus.la_data_out !== '0) begin
            errors++; $display("FAIL ar_async got %h exp 0", bus.la_data_out);
        end
        @(posedge wb_clk_i);
        #1;
        checks++;
        if (bus.la_data_out !== '0 || bus.irq !== 1'b0) begin
            errors++; $display("FAIL ar_held got %h/%b exp 0/0", bus.la_data_out, bus.irq);
        end
        #2;
        resetb = 1'b1;
        model_reset();
        for (int n = 1; n <= 4; n++) begin
            tick();
            checks++;
            if (bus.la_data_out !== exp_vec()) begin
                errors++; $display("FAIL ar_resume_vec n=%0d got %h exp %h", n, bus.la_data_out, exp_vec());
            end
            if (n >= LT) begin
                checks++;
                if (bank_of(bus.la_data_out, 0) !== BW'(n - LT)) begin
                    errors++; $display("FAIL ar_resume n=%0d got %h exp %h", n, bank_of(bus.la_data_out, 0), n - LT);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] e;
        bus.mode_i = M_HOLD;
        do_reset();
        bus_w.la_oenb = '0;
        bus_w.mode_i  = M_CNT;
        for (int n = 1; n <= 20; n++) begin
            tick();
            e = 4'((n - 1) % 16);
            checks++;
            if (bus_w.la_data_out !== {e, e}) begin
                errors++; $display("FAIL wrap n=%0d got %h exp %h", n, bus_w.la_data_out, {e, e});
            end
        end
        bus_w.mode_i = M_HOLD;
    endtask

    initial begin
        bus_w.la_data_in = '0;
        bus_w.la_oenb    = '0;
        bus_w.mode_i     = M_HOLD;
        bus_w.chg_clr_i  = 1'b0;
        model_reset();
        test_reset();
        test_swap_latency();
        test_invert_mask();
        test_count();
        test_hold();
        test_change_irq();
        test_random();
        test_async_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
